systolic_result_drain: RTL



---
 rtl/systolic_result_drain_pkg.sv | 25 ++
 rtl/drain_shadow_bank.sv | 38 +++
 rtl/systolic_result_drain.sv | 111 +++++++++++
 3 files changed

// File: rtl/systolic_result_drain_pkg.sv
// Shared types and width helpers for the systolic result drain (state encoding, clog2, wait-count width).
// Feature macro RESULT_RELU_EN is consumed by drain_shadow_bank; nothing here depends on it.
package systolic_result_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DWIDTH_DEF = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Wide enough for k_len max + NUM_COLS - 1 + MAC_LAT without wrap.
  function automatic int wait_cnt_w(input int kw, input int ncols);
    return kw + clog2(ncols) + 2;
  endfunction

endpackage

// File: rtl/drain_shadow_bank.sv
// Shadow bank of NUM_COLS column results: whole-bank load, indexed read.
// With RESULT_RELU_EN defined, negative (signed) values are stored as zero at load.
module drain_shadow_bank
  import systolic_result_drain_pkg::*;
#(
  parameter int DWIDTH   = DWIDTH_DEF,
  parameter int NUM_COLS = 4,
  parameter int IW       = clog2(NUM_COLS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_i,
  input  logic [NUM_COLS*DWIDTH-1:0] data_i,
  input  logic [IW-1:0]              rd_idx_i,
  output logic [DWIDTH-1:0]          rd_data_o
);

  logic [DWIDTH-1:0] bank_q [NUM_COLS];

  function automatic logic [DWIDTH-1:0] cap_val(input logic [DWIDTH-1:0] v);
`ifdef RESULT_RELU_EN
    return v[DWIDTH-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NUM_COLS; j++) bank_q[j] <= '0;
    end else if (load_i) begin
      for (int j = 0; j < NUM_COLS; j++) bank_q[j] <= cap_val(data_i[j*DWIDTH +: DWIDTH]);
    end
  end

  assign rd_data_o = bank_q[rd_idx_i];

endmodule

// File: rtl/systolic_result_drain.sv
// Waits out tile skew + MAC latency, snapshots the bottom-row results, then streams them one column per beat.
// Optional RESULT_RELU_EN clamps negative results at capture (handled in drain_shadow_bank); timing unchanged.
module systolic_result_drain
  import systolic_result_drain_pkg::*;
#(
  parameter int DWIDTH   = DWIDTH_DEF,
  parameter int NUM_COLS = 4,
  parameter int MAC_LAT  = 1,
  parameter int KW       = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [KW-1:0]              k_len,
  input  logic [NUM_COLS*DWIDTH-1:0] in_c,
  output logic [DWIDTH-1:0]          out_data,
  output logic [clog2(NUM_COLS)-1:0] out_col,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done
);

  localparam int CW = wait_cnt_w(KW, NUM_COLS);
  localparam int IW = clog2(NUM_COLS);
  localparam logic [IW-1:0] LAST_COL = IW'(NUM_COLS - 1);
  localparam logic [CW-1:0] W_EXTRA  = CW'(NUM_COLS - 1 + MAC_LAT);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   col_q, col_d;
  logic            done_q, done_d;
  logic            load;
  logic            xfer;

  assign xfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (k_len != '0)) begin
          state_d = WAIT;
          cnt_d   = CW'(k_len) + W_EXTRA;
        end
      end
      WAIT: begin
        // Capture lands exactly W edges after the start edge.
        if (cnt_q == CW'(1)) begin
          load    = 1'b1;
          state_d = DRAIN;
          cnt_d   = '0;
          col_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DRAIN: begin
        if (xfer) begin
          if (col_q == LAST_COL) begin
            state_d = IDLE;
            col_d   = '0;
            done_d  = 1'b1;
          end else begin
            col_d = col_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  drain_shadow_bank #(
    .DWIDTH   (DWIDTH),
    .NUM_COLS (NUM_COLS),
    .IW       (IW)
  ) u_bank (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .data_i    (in_c),
    .rd_idx_i  (col_q),
    .rd_data_o (out_data)
  );

  assign out_valid = (state_q == DRAIN);
  assign out_col   = col_q;
  assign out_last  = out_valid && (col_q == LAST_COL);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule
